countdown_timer_bcd: RTL and testbench

COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

---
 rtl/countdown_pkg.sv | 39 +++
 rtl/countdown_timer_bcd_digit.sv | 38 +++
 rtl/countdown_timer_bcd.sv | 124 ++++++++++++
 tb/tb_countdown_timer_bcd.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared constants and helpers for the BCD countdown timer.
package countdown_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;

    localparam logic [2:0] DIG_HUND_ONES = 3'd0;
    localparam logic [2:0] DIG_HUND_TENS = 3'd1;
    localparam logic [2:0] DIG_SEC_ONES  = 3'd2;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd3;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd4;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd5;

    function automatic logic [3:0] digit_max(
        input logic [2:0] idx,
        input logic [3:0] sec_max,
        input logic [3:0] min_max
    );
        logic [3:0] m;
        m = DIGIT_MAX_ONES;
        if (idx == DIG_SEC_TENS) m = sec_max;
        if (idx == DIG_MIN_TENS) m = min_max;
        return m;
    endfunction

    function automatic logic [3:0] sat_digit(
        input logic [3:0] v,
        input logic [3:0] max
    );
        return (v > max) ? max : v;
    endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD down-counting digit with parallel load and borrow chain.
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter int MAX = int'(DIGIT_MAX_ONES)
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       borrow_in,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       borrow_out,
    output logic [3:0] Q
);

    localparam logic [3:0] MAX_V = 4'(MAX);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (borrow_in) begin
            q_d = (q_q == 4'd0) ? MAX_V : q_q - 4'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) q_q <= 4'd0;
        else         q_q <= q_d;
    end

    assign borrow_out = borrow_in && (q_q == 4'd0);
    assign Q          = q_q;

endmodule

// File: rtl/countdown_timer_bcd.sv
// mm:ss.hh BCD countdown timer with set/hold/start control.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from preset on reaching zero.
module countdown_timer_bcd
    import countdown_pkg::*;
#(
    parameter int SEC_TENS_MAX = 5,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        E,
    input  logic        start,
    input  logic        hold,
    input  logic        set,
    input  logic [2:0]  set_sel,
    input  logic [3:0]  set_num,
    output logic [23:0] Q,
    output logic        running,
    output logic        done
);

    localparam logic [3:0] SEC_MAX = 4'(SEC_TENS_MAX);
    localparam logic [3:0] MIN_MAX = 4'(MIN_TENS_MAX);

    logic [1:0]  state_q, state_d;
    logic [23:0] preset_q, preset_d;
    logic        running_q, running_d;
    logic        done_q, done_d;

    logic        sel_valid;
    logic        set_act;
    logic [3:0]  set_val;
    logic        tick;
    logic        q_zero;
    logic        last;
    logic        reload;
    logic [6:0]  borrow;
    logic [5:0]  load;
    logic [23:0] load_val;

    assign sel_valid = (set_sel < 3'd6);
    assign set_act   = !set && sel_valid;
    assign set_val   = sat_digit(set_num,
                                 digit_max(set_sel, SEC_MAX, MIN_MAX));

    assign tick   = (state_q == ST_RUN) && set && hold && E;
    assign q_zero = (Q == 24'h000000);
    assign last   = tick && (Q == 24'h000001);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign reload = last && (preset_q != 24'h000000);
`else
    assign reload = 1'b0;
`endif

    assign borrow[0] = tick;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        localparam int M = (i == int'(DIG_SEC_TENS)) ? SEC_TENS_MAX :
                           (i == int'(DIG_MIN_TENS)) ? MIN_TENS_MAX :
                           int'(DIGIT_MAX_ONES);

        assign load[i] = (set_act && (set_sel == 3'(i))) || reload;
        assign load_val[4*i+:4] = reload ? preset_q[4*i+:4] : set_val;

        bcd_down_digit #(.MAX(M)) u_digit (
            .Clock      (Clock),
            .Resetn     (Resetn),
            .borrow_in  (borrow[i]),
            .load       (load[i]),
            .load_val   (load_val[4*i+:4]),
            .borrow_out (borrow[i+1]),
            .Q          (Q[4*i+:4])
        );
    end

    always_comb begin
        preset_d = preset_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (set_act && (set_sel == 3'(i))) preset_d[4*i+:4] = set_val;
        end
    end

    // set beats hold, hold beats start/E; an invalid set_sel still stalls
    always_comb begin
        state_d = state_q;
        if (!set) begin
            if (sel_valid) state_d = ST_IDLE;
        end else if (!hold) begin
            if (state_q == ST_RUN) state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (start) state_d = q_zero ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if ((last && !reload) || borrow[6]) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign running_d = (state_d == ST_RUN) && !reload;
    assign done_d    = (state_d == ST_DONE) || reload;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            preset_q  <= 24'h000000;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed self-checking bench for countdown_timer_bcd.
module tb_countdown_timer_bcd;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        E;
    logic        start;
    logic        hold;
    logic        set;
    logic [2:0]  set_sel;
    logic [3:0]  set_num;
    logic [23:0] Q;
    logic        running;
    logic        done;

    int checks   = 0;
    int failures = 0;

    countdown_timer_bcd #(.SEC_TENS_MAX(5), .MIN_TENS_MAX(5)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .E       (E),
        .start   (start),
        .hold    (hold),
        .set     (set),
        .set_sel (set_sel),
        .set_num (set_num),
        .Q       (Q),
        .running (running),
        .done    (done)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic load_digit(input logic [2:0] sel, input logic [3:0] num);
        set     = 1'b0;
        set_sel = sel;
        set_num = num;
        cyc();
        set     = 1'b1;
    endtask

    initial begin
        Resetn  = 1'b0;
        E       = 1'b0;
        start   = 1'b0;
        hold    = 1'b1;
        set     = 1'b1;
        set_sel = 3'd0;
        set_num = 4'd0;
        #12;
        chk("rst_q", Q, 24'h000000);
        chk("rst_running", 24'(running), 24'd0);
        chk("rst_done", 24'(done), 24'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        cyc();

        // 00:00.03 counts to zero
        load_digit(3'd0, 4'd3);
        chk("load3", Q, 24'h000003);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("run_running", 24'(running), 24'd1);
        E = 1'b1;
        cyc();
        chk("tick1", Q, 24'h000002);
        cyc();
        chk("tick2", Q, 24'h000001);
        cyc();
        E = 1'b0;
        chk("tick3", Q, 24'h000000);
        chk("tick3_done", 24'(done), 24'd1);
        chk("tick3_running", 24'(running), 24'd0);

        // DONE ignores E and start
        E     = 1'b1;
        start = 1'b1;
        cyc(2);
        E     = 1'b0;
        start = 1'b0;
        chk("done_hold_q", Q, 24'h000000);
        chk("done_hold_done", 24'(done), 24'd1);

        // saturation and ignored selectors
        load_digit(3'd3, 4'd9);
        chk("sat_sec_tens", Q, 24'h005000);
        chk("set_idle_done", 24'(done), 24'd0);
        load_digit(3'd0, 4'hF);
        chk("sat_hund", Q, 24'h005009);
        load_digit(3'd6, 4'd7);
        chk("sel6_ignored", Q, 24'h005009);

        // 01:00.00 borrow across all digits
        load_digit(3'd0, 4'd0);
        load_digit(3'd3, 4'd0);
        load_digit(3'd4, 4'd1);
        chk("load_1min", Q, 24'h010000);
        start = 1'b1;
        cyc();
        start = 1'b0;
        E = 1'b1;
        cyc();
        E = 1'b0;
        chk("borrow_1min", Q, 24'h005999);

        // hold for 50 ticks at 00:10.00
        load_digit(3'd0, 4'd0);
        load_digit(3'd1, 4'd0);
        load_digit(3'd2, 4'd0);
        load_digit(3'd3, 4'd1);
        chk("load_10s", Q, 24'h001000);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("run10_running", 24'(running), 24'd1);
        hold = 1'b0;
        E    = 1'b1;
        cyc(50);
        chk("hold_q", Q, 24'h001000);
        chk("hold_running", 24'(running), 24'd0);
        hold  = 1'b1;
        E     = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume_running", 24'(running), 24'd1);
        E = 1'b1;
        cyc();
        chk("resume_tick", Q, 24'h000999);

        // asynchronous reset between edges while running
        #2;
        Resetn = 1'b0;
        #1;
        chk("async_q", Q, 24'h000000);
        chk("async_running", 24'(running), 24'd0);
        chk("async_done", 24'(done), 24'd0);
        #1;
        Resetn = 1'b1;
        cyc();
        E = 1'b0;
        chk("post_rst_q", Q, 24'h000000);
        chk("post_rst_running", 24'(running), 24'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        load_digit(3'd0, 4'd2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        E = 1'b1;
        cyc();
        chk("ar_t1", Q, 24'h000001);
        chk("ar_t1_done", 24'(done), 24'd0);
        cyc();
        chk("ar_t2", Q, 24'h000002);
        chk("ar_t2_done", 24'(done), 24'd1);
        cyc();
        chk("ar_t3", Q, 24'h000001);
        chk("ar_t3_done", 24'(done), 24'd0);
        cyc();
        chk("ar_t4", Q, 24'h000002);
        chk("ar_t4_done", 24'(done), 24'd1);
        E = 1'b0;
`else
        load_digit(3'd0, 4'd2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        E = 1'b1;
        cyc();
        chk("nr_t1", Q, 24'h000001);
        cyc();
        chk("nr_t2", Q, 24'h000000);
        chk("nr_t2_done", 24'(done), 24'd1);
        cyc();
        E = 1'b0;
        chk("nr_t3", Q, 24'h000000);
        chk("nr_t3_running", 24'(running), 24'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
